// File: rtl/result_bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD result converter.
package result_bcd_converter_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Smallest digit count whose decimal range covers every WIDTH-bit value.
    function automatic int unsigned min_bcd_digits(input int unsigned width);
        longint unsigned max_val;
        longint unsigned pow10;
        int unsigned     digits;
        max_val = (longint'(1) << width) - 1;
        pow10   = 10;
        digits  = 1;
        while (pow10 <= max_val) begin
            pow10  = pow10 * 10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/result_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module result_bcd_converter_bcd_digit_adjust
    import result_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_c
);

    // Conditional +3 so the following left shift carries correctly into the next digit.
    always_comb begin
        digit_c = digit_i;
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_c = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Multi-cycle binary to packed-BCD converter, one bit per clock (shift-and-add-3).
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = min_bcd_digits(WIDTH),
    parameter bit          AUTO   = 1'b0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [WIDTH-1:0]              data_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          valid
);

    localparam int unsigned SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   last_value_q, last_value_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;

    logic [SCR_W-1:0]   scratch_adj_c;
    logic               start_cond_c;

    // Per-digit +3 correction applied to the current scratch before each shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        result_bcd_converter_bcd_digit_adjust u_bcd_digit_adjust (
            .digit_i (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_c (scratch_adj_c[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Explicit request, or in auto mode any change from the last converted value.
    assign start_cond_c = start | (AUTO & (data_in != last_value_q));

    // Next-state and datapath: capture, shift WIDTH times, then publish the result.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        count_d      = count_q;
        last_value_d = last_value_q;
        bcd_d        = bcd_q;
        done_d       = 1'b0;
        valid_d      = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start_cond_c) begin
                    shift_d      = data_in;
                    last_value_d = data_in;
                    scratch_d    = '0;
                    count_d      = CNT_W'(WIDTH);
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, shift_d} = {scratch_adj_c[SCR_W-2:0], shift_q, 1'b0};
                count_d              = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SHIFT) || (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            scratch_q    <= '0;
            count_q      <= '0;
            last_value_q <= '0;
            bcd_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            scratch_q    <= scratch_d;
            count_q      <= count_d;
            last_value_q <= last_value_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign valid   = valid_q;

endmodule
